alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 59 +++++
 rtl/alu_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// alu_sequencer_if : command / response / ALU-side bundle for alu_sequencer
// Revision 1.0
// ============================================================================
interface alu_sequencer_if #(
  parameter int WORD_SIZE = 32
) ();
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [3:0]           cmd_control;
  logic [WORD_SIZE-1:0] cmd_a;
  logic [WORD_SIZE-1:0] cmd_b;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WORD_SIZE-1:0] rsp_result;
  logic                 rsp_zero;
  logic                 rsp_cout;
  logic                 rsp_overflow;
  logic                 rsp_invalid;
  logic                 rsp_timeout;

  logic                 alu_start;
  logic [3:0]           alu_control;
  logic [WORD_SIZE-1:0] alu_a;
  logic [WORD_SIZE-1:0] alu_b;
  logic                 alu_finished;
  logic                 alu_zero;
  logic                 alu_cout;
  logic                 alu_err_overflow;
  logic                 alu_err_invalid_control;
  logic [WORD_SIZE-1:0] alu_result;

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_control, cmd_a, cmd_b,
    output cmd_ready,
    output rsp_valid, rsp_result, rsp_zero, rsp_cout, rsp_overflow,
           rsp_invalid, rsp_timeout,
    input  rsp_ready,
    output alu_start, alu_control, alu_a, alu_b,
    input  alu_finished, alu_zero, alu_cout, alu_err_overflow,
           alu_err_invalid_control, alu_result
  );

  // Requester / ALU side
  modport master (
    output cmd_valid, cmd_control, cmd_a, cmd_b,
    input  cmd_ready,
    input  rsp_valid, rsp_result, rsp_zero, rsp_cout, rsp_overflow,
           rsp_invalid, rsp_timeout,
    output rsp_ready,
    input  alu_start, alu_control, alu_a, alu_b,
    output alu_finished, alu_zero, alu_cout, alu_err_overflow,
           alu_err_invalid_control, alu_result
  );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// alu_sequencer : issues one command at a time to an external ALU, bounds the
//                 wait with a timeout and holds the response until accepted.
// Revision 1.0
// ============================================================================
module alu_sequencer #(
  parameter int WORD_SIZE = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic            clk,
  input  logic            reset,
  alu_sequencer_if.slave  bus,
  output logic            busy,
  output logic [15:0]     op_count
);

  localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           timer_q, timer_d;
  logic [3:0]           alu_control_q, alu_control_d;
  logic [WORD_SIZE-1:0] alu_a_q, alu_a_d;
  logic [WORD_SIZE-1:0] alu_b_q, alu_b_d;
  logic [WORD_SIZE-1:0] rsp_result_q, rsp_result_d;
  logic                 rsp_zero_q, rsp_zero_d;
  logic                 rsp_cout_q, rsp_cout_d;
  logic                 rsp_overflow_q, rsp_overflow_d;
  logic                 rsp_invalid_q, rsp_invalid_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic [15:0]          op_count_q, op_count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      alu_control_q  <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_cout_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_invalid_q  <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      op_count_q     <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      alu_control_q  <= alu_control_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_cout_q     <= rsp_cout_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_invalid_q  <= rsp_invalid_d;
      rsp_timeout_q  <= rsp_timeout_d;
      op_count_q     <= op_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    alu_control_d  = alu_control_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_cout_d     = rsp_cout_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_invalid_d  = rsp_invalid_q;
    rsp_timeout_d  = rsp_timeout_q;
    op_count_d     = op_count_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          alu_control_d = bus.cmd_control;
          alu_a_d       = bus.cmd_a;
          alu_b_d       = bus.cmd_b;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = TIMER_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        // A finish on the expiring cycle still counts as a normal completion.
        if (bus.alu_finished) begin
          rsp_result_d   = bus.alu_result;
          rsp_zero_d     = bus.alu_zero;
          rsp_cout_d     = bus.alu_cout;
          rsp_overflow_d = bus.alu_err_overflow;
          rsp_invalid_d  = bus.alu_err_invalid_control;
          rsp_timeout_d  = 1'b0;
          state_d        = RESP;
        end else if (timer_q <= 8'd1) begin
          timer_d        = '0;
          rsp_result_d   = '0;
          rsp_zero_d     = 1'b0;
          rsp_cout_d     = 1'b0;
          rsp_overflow_d = 1'b0;
          rsp_invalid_d  = 1'b0;
          rsp_timeout_d  = 1'b1;
          state_d        = RESP;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready    = (state_q == IDLE);
  assign bus.alu_start    = (state_q == ISSUE);
  assign bus.alu_control  = alu_control_q;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_cout     = rsp_cout_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_invalid  = rsp_invalid_q;
  assign bus.rsp_timeout  = rsp_timeout_q;
  assign busy             = (state_q != IDLE);
  assign op_count         = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alu_sequencer : directed self-checking bench for alu_sequencer (TIMEOUT=4)
// Revision 1.0
// ============================================================================
module tb_alu_sequencer;

  logic        clk;
  logic        reset;
  logic        busy;
  logic [15:0] op_count;
  int          checks;
  int          failures;
  logic [15:0] exp_count;

  alu_sequencer_if #(.WORD_SIZE(32)) bus ();

  alu_sequencer #(.WORD_SIZE(32), .TIMEOUT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_alu(input logic fin, input logic [31:0] res, input logic z,
                         input logic co, input logic ov, input logic inv);
    bus.alu_finished            = fin;
    bus.alu_result              = res;
    bus.alu_zero                = z;
    bus.alu_cout                = co;
    bus.alu_err_overflow        = ov;
    bus.alu_err_invalid_control = inv;
  endtask

  // Presents one command for exactly the accepting edge.
  task automatic send_cmd(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    bus.cmd_valid   = 1'b1;
    bus.cmd_control = ctrl;
    bus.cmd_a       = a;
    bus.cmd_b       = b;
    tick();
    bus.cmd_valid   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.alu_start !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl got valid=%b busy=%b start=%b exp 0 0 0", bus.rsp_valid, busy, bus.alu_start); end
    checks++; if (op_count !== 16'd0 || bus.rsp_result !== 32'd0 || bus.alu_a !== 32'd0 || bus.alu_control !== 4'd0) begin
      failures++; $display("FAIL reset_data got cnt=%0h res=%0h a=%0h ctl=%0h exp all 0", op_count, bus.rsp_result, bus.alu_a, bus.alu_control); end
    reset = 1'b0;
    tick();
    checks++; if (bus.cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b exp=1", bus.cmd_ready); end
    exp_count = 16'd0;
  endtask

  task automatic test_reset_mid_wait();
    set_alu(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_cmd(4'h2, 32'd3, 32'd4);
    tick();                               // now in WAIT
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.alu_start !== 1'b0 || busy !== 1'b0 || op_count !== exp_count || bus.cmd_ready !== 1'b1) begin
      failures++; $display("FAIL midwait_reset got start=%b busy=%b cnt=%0h rdy=%b exp 0 0 %0h 1", bus.alu_start, busy, op_count, bus.cmd_ready, exp_count); end
    tick();
    reset = 1'b0;
    tick();
    set_alu(1'b1, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    send_cmd(4'h2, 32'd3, 32'd4);
    tick();
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd7 || bus.rsp_timeout !== 1'b0) begin
      failures++; $display("FAIL midwait_next got valid=%b res=%0d to=%b exp 1 7 0", bus.rsp_valid, bus.rsp_result, bus.rsp_timeout); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    checks++; if (op_count !== exp_count) begin
      failures++; $display("FAIL midwait_count got=%0h exp=%0h", op_count, exp_count); end
  endtask

  task automatic test_add();
    set_alu(1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    send_cmd(4'h2, 32'd5, 32'd7);         // edge N
    checks++; if (bus.alu_start !== 1'b1 || busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      failures++; $display("FAIL add_issue got start=%b busy=%b rdy=%b exp 1 1 0", bus.alu_start, busy, bus.cmd_ready); end
    checks++; if (bus.alu_control !== 4'h2 || bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7) begin
      failures++; $display("FAIL add_operands got ctl=%0h a=%0d b=%0d exp 2 5 7", bus.alu_control, bus.alu_a, bus.alu_b); end
    tick();                               // edge N+1
    checks++; if (bus.alu_start !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      failures++; $display("FAIL add_wait got start=%b valid=%b exp 0 0", bus.alu_start, bus.rsp_valid); end
    tick();                               // edge N+2
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd12 || bus.rsp_zero !== 1'b0 || bus.rsp_overflow !== 1'b0) begin
      failures++; $display("FAIL add_rsp got valid=%b res=%0d z=%b ov=%b exp 1 12 0 0", bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_overflow); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    checks++; if (op_count !== exp_count || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      failures++; $display("FAIL add_done got cnt=%0h valid=%b rdy=%b exp %0h 0 1", op_count, bus.rsp_valid, bus.cmd_ready, exp_count); end
  endtask

  task automatic test_sub_overflow();
    set_alu(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    send_cmd(4'h6, 32'h8000_0000, 32'd1);
    tick();
    tick();
    checks++; if (bus.rsp_result !== 32'h7FFF_FFFF || bus.rsp_overflow !== 1'b1 || bus.rsp_timeout !== 1'b0 || bus.rsp_cout !== 1'b0) begin
      failures++; $display("FAIL sub_ovf got res=%0h ov=%b to=%b co=%b exp 7fffffff 1 0 0", bus.rsp_result, bus.rsp_overflow, bus.rsp_timeout, bus.rsp_cout); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    exp_count = exp_count + 16'd1;
  endtask

  task automatic test_timeout();
    // ALU never finishes; stale result/flags must not leak into the response
    set_alu(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1);
    send_cmd(4'h1, 32'd1, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (bus.rsp_valid !== 1'b0) begin
        failures++; $display("FAIL timeout_early edge=%0d got valid=%b exp 0", i, bus.rsp_valid); end
    end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_timeout !== 1'b1 || bus.rsp_result !== 32'd0) begin
      failures++; $display("FAIL timeout_rsp got valid=%b to=%b res=%0h exp 1 1 0", bus.rsp_valid, bus.rsp_timeout, bus.rsp_result); end
    checks++; if (bus.rsp_zero !== 1'b0 || bus.rsp_cout !== 1'b0 || bus.rsp_overflow !== 1'b0 || bus.rsp_invalid !== 1'b0) begin
      failures++; $display("FAIL timeout_flags got z=%b co=%b ov=%b inv=%b exp 0 0 0 0", bus.rsp_zero, bus.rsp_cout, bus.rsp_overflow, bus.rsp_invalid); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    exp_count = exp_count + 16'd1;

    // Finish arrives on the last permitted WAIT cycle
    set_alu(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_cmd(4'h1, 32'd2, 32'd3);
    for (int i = 1; i <= 4; i++) tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin
      failures++; $display("FAIL late_finish_early got valid=%b exp 0", bus.rsp_valid); end
    set_alu(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_timeout !== 1'b0 || bus.rsp_result !== 32'h55) begin
      failures++; $display("FAIL late_finish got valid=%b to=%b res=%0h exp 1 0 55", bus.rsp_valid, bus.rsp_timeout, bus.rsp_result); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    exp_count = exp_count + 16'd1;
  endtask

  task automatic test_back_to_back();
    set_alu(1'b1, 32'h1111, 1'b0, 1'b0, 1'b0, 1'b0);
    send_cmd(4'h3, 32'd1, 32'd2);
    tick();
    tick();                               // RESP, held by rsp_ready=0
    bus.cmd_valid   = 1'b1;
    bus.cmd_control = 4'h4;
    bus.cmd_a       = 32'd9;
    bus.cmd_b       = 32'd10;
    bus.alu_result  = 32'h2222;
    for (int i = 0; i < 10; i++) begin
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'h1111 || bus.cmd_ready !== 1'b0 || bus.alu_a !== 32'd1) begin
        failures++; $display("FAIL bp_hold cyc=%0d got valid=%b res=%0h rdy=%b a=%0d exp 1 1111 0 1", i, bus.rsp_valid, bus.rsp_result, bus.cmd_ready, bus.alu_a); end
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    checks++; if (bus.cmd_ready !== 1'b1 || op_count !== exp_count || bus.rsp_valid !== 1'b0) begin
      failures++; $display("FAIL bp_idle got rdy=%b cnt=%0h valid=%b exp 1 %0h 0", bus.cmd_ready, op_count, bus.rsp_valid, exp_count); end
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if (bus.alu_start !== 1'b1 || bus.alu_a !== 32'd9 || bus.alu_b !== 32'd10 || bus.alu_control !== 4'h4) begin
      failures++; $display("FAIL bp_second got start=%b a=%0d b=%0d ctl=%0h exp 1 9 10 4", bus.alu_start, bus.alu_a, bus.alu_b, bus.alu_control); end
    tick();
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'h2222) begin
      failures++; $display("FAIL bp_second_rsp got valid=%b res=%0h exp 1 2222", bus.rsp_valid, bus.rsp_result); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    exp_count = exp_count + 16'd1;
  endtask

  task automatic test_wrap_invalid();
    force dut.op_count_q = 16'hFFFF;
    tick();
    release dut.op_count_q;
    tick();
    exp_count = 16'hFFFF;
    checks++; if (op_count !== 16'hFFFF) begin
      failures++; $display("FAIL wrap_preset got=%0h exp=ffff", op_count); end
    set_alu(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    send_cmd(4'hF, 32'd8, 32'd9);
    checks++; if (bus.alu_control !== 4'hF) begin
      failures++; $display("FAIL inv_forward got=%0h exp=f", bus.alu_control); end
    tick();
    tick();
    checks++; if (bus.rsp_invalid !== 1'b1 || bus.rsp_zero !== 1'b1 || bus.rsp_timeout !== 1'b0) begin
      failures++; $display("FAIL inv_rsp got inv=%b z=%b to=%b exp 1 1 0", bus.rsp_invalid, bus.rsp_zero, bus.rsp_timeout); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++; if (op_count !== 16'h0000) begin
      failures++; $display("FAIL wrap_count got=%0h exp=0", op_count); end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    exp_count       = 16'd0;
    reset           = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_control = 4'h0;
    bus.cmd_a       = 32'd0;
    bus.cmd_b       = 32'd0;
    bus.rsp_ready   = 1'b0;
    set_alu(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    test_reset();
    test_reset_mid_wait();
    test_add();
    test_sub_overflow();
    test_timeout();
    test_back_to_back();
    test_wrap_invalid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
